control_sequencer: RTL and testbench

//  Hardwired control unit for the 32-bit datapath. It drives every Datapath

---
 rtl/control_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute FSM driving every control input of the 32-bit datapath.
// Build option MULDIV_EN adds the mul/div execute steps; without it those opcodes behave as nop.
module control_sequencer #(
   parameter int OPW = 5,
   parameter int IRW = 32
) (
   input  logic           clk,
   input  logic           clr_n,
   input  logic [IRW-1:0] IR,
   input  logic           CON_FF,
   input  logic           Stop,
   output logic           Run,
   output logic           R_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, In_out, C_out, BAout,
   output logic           Rin, MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortin,
   output logic           Gra, Grb, Grc,
   output logic           IncPC, Read, Write,
   output logic [OPW-1:0] op_sel
);

   typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_e;

   localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
   localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
   localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
   localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
   localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
   localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
   localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10101);
   localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10110);
   localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b10111);
   localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11000);
   localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

   state_e         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic           stop_q, stop_d;
   logic           run_q, run_d;

   logic [OPW-1:0] ir_op, cur_op;
   logic           is_alu, is_imm, is_addr, is_unary, is_md;
   logic           unused_ir;

   assign ir_op     = IR[IRW-1 -: OPW];
   assign unused_ir = ^IR[IRW-OPW-1:0];

   // The opcode is not latched until the end of T3, so T3 itself decodes straight from IR.
   assign cur_op   = (state_q == T3) ? ir_op : op_q;
   assign is_alu   = (cur_op >= OP_ADD) && (cur_op <= OP_ROL);
   assign is_imm   = (cur_op >= OP_ADDI) && (cur_op <= OP_ORI);
   assign is_addr  = (cur_op == OP_LD) || (cur_op == OP_LDI) || (cur_op == OP_ST);
   assign is_unary = (cur_op == OP_NEG) || (cur_op == OP_NOT);
`ifdef MULDIV_EN
   assign is_md    = (cur_op == OP_MUL) || (cur_op == OP_DIV);
`else
   assign is_md    = 1'b0;
`endif

   // Final execute step of each opcode; 0 means no execute steps (nop, halt, undefined).
   function automatic logic [2:0] last_step(input logic [OPW-1:0] op);
      logic [2:0] n;
      n = 3'd0;
      if (op == OP_LD || op == OP_ST) n = 3'd7;
      else if (op == OP_LDI || (op >= OP_ADD && op <= OP_ORI)) n = 3'd5;
      else if (op == OP_NEG || op == OP_NOT) n = 3'd4;
      else if (op == OP_BR) n = 3'd6;
      else if (op == OP_JR || op == OP_IN || op == OP_OUT || op == OP_MFHI || op == OP_MFLO) n = 3'd3;
`ifdef MULDIV_EN
      else if (op == OP_MUL || op == OP_DIV) n = 3'd6;
`endif
      return n;
   endfunction

   function automatic logic [OPW-1:0] imm_alu(input logic [OPW-1:0] op);
      case (op)
         OP_ANDI: return OP_AND;
         OP_ORI:  return OP_OR;
         default: return OP_ADD;
      endcase
   endfunction

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= T0;
         op_q    <= '0;
         stop_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         stop_q  <= stop_d;
         run_q   <= run_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      stop_d  = stop_q;
      run_d   = 1'b1;
      if (!run_q) begin
         // first clock after reset release only arms the sequencer; T0 is presented next cycle
         state_d = T0;
      end else begin
         case (state_q)
            T0:     state_d = T1;
            T1:     state_d = T2;
            T2: begin
               stop_d = Stop;
               if (ir_op == OP_HALT)          state_d = HALTED;
               else if (last_step(ir_op) == 3'd0) state_d = Stop ? HALTED : T0;
               else                           state_d = T3;
            end
            HALTED: state_d = HALTED;
            default: begin
               if (state_q == T3) op_d = ir_op;
               if (last_step(cur_op) <= state_q[2:0]) state_d = stop_q ? HALTED : T0;
               else                                   state_d = state_e'(state_q + 4'd1);
            end
         endcase
      end
   end

   always_comb begin
      {R_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, In_out, C_out, BAout} = '0;
      {Rin, MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortin} = '0;
      {Gra, Grb, Grc, IncPC, Read, Write} = '0;
      op_sel = '0;
      Run    = run_q && (state_q != HALTED);
      if (run_q) begin
         case (state_q)
            T0: begin PC_out = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
            T1: begin Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDR_out = 1'b1; IRin = 1'b1; end
            T3: begin
               if (is_alu || is_imm) begin Grb = 1'b1; R_out = 1'b1; Yin = 1'b1; end
               else if (is_addr) begin Grb = 1'b1; BAout = 1'b1; R_out = 1'b1; Yin = 1'b1; end
               else if (is_unary) begin Grb = 1'b1; R_out = 1'b1; op_sel = cur_op; Zlowin = 1'b1; end
               else if (is_md) begin Gra = 1'b1; R_out = 1'b1; Yin = 1'b1; end
               else begin
                  case (cur_op)
                     OP_BR:   begin Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; end
                     OP_JR:   begin Gra = 1'b1; R_out = 1'b1; PCin = 1'b1; end
                     OP_IN:   begin In_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; OutPortin = 1'b1; end
                     OP_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     OP_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     default: ;
                  endcase
               end
            end
            T4: begin
               if (is_alu) begin Grc = 1'b1; R_out = 1'b1; op_sel = cur_op; Zlowin = 1'b1; end
               else if (is_imm) begin C_out = 1'b1; op_sel = imm_alu(cur_op); Zlowin = 1'b1; end
               else if (is_addr) begin C_out = 1'b1; op_sel = OP_ADD; Zlowin = 1'b1; end
               else if (is_unary) begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               else if (cur_op == OP_BR) begin PC_out = 1'b1; Yin = 1'b1; end
               else if (is_md) begin
                  Grb = 1'b1; R_out = 1'b1; op_sel = cur_op; Zlowin = 1'b1; Zhighin = 1'b1;
               end
            end
            T5: begin
               if (is_alu || is_imm || cur_op == OP_LDI) begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               else if (cur_op == OP_LD || cur_op == OP_ST) begin Zlo_out = 1'b1; MARin = 1'b1; end
               else if (cur_op == OP_BR) begin C_out = 1'b1; op_sel = OP_ADD; Zlowin = 1'b1; end
               else if (is_md) begin Zlo_out = 1'b1; LOin = 1'b1; end
            end
            T6: begin
               if (cur_op == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
               else if (cur_op == OP_ST) begin Gra = 1'b1; R_out = 1'b1; MDRin = 1'b1; end
               else if (cur_op == OP_BR) begin Zlo_out = CON_FF; PCin = CON_FF; end
               else if (is_md) begin Zhi_out = 1'b1; HIin = 1'b1; end
            end
            T7: begin
               if (cur_op == OP_LD) begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               else if (cur_op == OP_ST) Write = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: each task replays a hand-written per-cycle table of
// expected control words and ALU selects, starting from a fresh reset.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [31:0] IR;
   logic        CON_FF;
   logic        Stop;
   logic        Run;
   logic        R_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, In_out, C_out, BAout;
   logic        Rin, MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortin;
   logic        Gra, Grb, Grc, IncPC, Read, Write;
   logic [4:0]  op_sel;
   logic [28:0] ctl;

   int tests = 0;
   int fails = 0;

   control_sequencer #(.OPW(5), .IRW(32)) dut (
      .clk(clk), .clr_n(clr_n), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
      .R_out(R_out), .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
      .PC_out(PC_out), .MDR_out(MDR_out), .In_out(In_out), .C_out(C_out), .BAout(BAout),
      .Rin(Rin), .MARin(MARin), .Zlowin(Zlowin), .Zhighin(Zhighin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .op_sel(op_sel)
   );

   always #5 clk = ~clk;

   assign ctl = {Run, Write, Read, IncPC, Grc, Grb, Gra, OutPortin, CONin, LOin, HIin, Yin, IRin,
                 MDRin, PCin, Zhighin, Zlowin, MARin, Rin, BAout, C_out, In_out, MDR_out, PC_out,
                 Zlo_out, Zhi_out, LO_out, HI_out, R_out};

   localparam logic [28:0] R_OUT = 29'd1 << 0,  HI_OUT = 29'd1 << 1,  LO_OUT = 29'd1 << 2;
   localparam logic [28:0] ZHI_OUT = 29'd1 << 3, ZLO_OUT = 29'd1 << 4, PC_OUT = 29'd1 << 5;
   localparam logic [28:0] MDR_OUT = 29'd1 << 6, IN_OUT = 29'd1 << 7,  C_OUT = 29'd1 << 8;
   localparam logic [28:0] BA_OUT = 29'd1 << 9,  R_IN = 29'd1 << 10,   MAR_IN = 29'd1 << 11;
   localparam logic [28:0] ZLOW_IN = 29'd1 << 12, PC_IN = 29'd1 << 14, MDR_IN = 29'd1 << 15;
   localparam logic [28:0] IR_IN = 29'd1 << 16,  Y_IN = 29'd1 << 17,   CON_IN = 29'd1 << 20;
   localparam logic [28:0] GRA = 29'd1 << 22,    GRB = 29'd1 << 23,    GRC = 29'd1 << 24;
   localparam logic [28:0] INC_PC = 29'd1 << 25, READ = 29'd1 << 26,   WRITE = 29'd1 << 27;
   localparam logic [28:0] RUN = 29'd1 << 28;

   localparam logic [28:0] F0 = RUN | PC_OUT | MAR_IN | INC_PC | ZLOW_IN;
   localparam logic [28:0] F1 = RUN | ZLO_OUT | PC_IN | READ | MDR_IN;
   localparam logic [28:0] F2 = RUN | MDR_OUT | IR_IN;
   localparam logic [28:0] A3 = RUN | GRB | BA_OUT | R_OUT | Y_IN;
   localparam logic [28:0] A4 = RUN | C_OUT | ZLOW_IN;
   localparam logic [28:0] WB = RUN | ZLO_OUT | GRA | R_IN;

   localparam logic [31:0] I_LDI  = 32'h0A000054;
   localparam logic [31:0] I_ADD  = 32'h1A920000;
   localparam logic [31:0] I_ST   = 32'h10000000;
   localparam logic [31:0] I_LD   = 32'h00000000;
   localparam logic [31:0] I_BR   = 32'h90000000;
   localparam logic [31:0] I_NOP  = 32'hC8000000;
   localparam logic [31:0] I_HALT = 32'hD0000000;

   // Reset, load IR, release; returns 1 ns after the first edge following release (the T0 cycle).
   task automatic start(input logic [31:0] ir);
      clr_n = 1'b0;
      IR    = ir;
      Stop  = 1'b0;
      repeat (2) @(posedge clk);
      #3 clr_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr_n = 1'b0; IR = I_ADD; Stop = 1'b0; CON_FF = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (ctl !== 29'd0 || op_sel !== 5'd0) begin
         fails++;
         $display("FAIL reset_idle: ctl=%h op_sel=%b, expected ctl=0 op_sel=0", ctl, op_sel);
      end
      start(I_ADD);
      for (int i = 0; i < 5; i++) begin
         logic [28:0] e;
         logic [4:0]  o;
         if (i > 0) begin @(posedge clk); #1; end
         case (i)
            0: begin e = F0; o = 5'd0; end
            1: begin e = F1; o = 5'd0; end
            2: begin e = F2; o = 5'd0; end
            3: begin e = RUN | GRB | R_OUT | Y_IN; o = 5'd0; end
            default: begin e = RUN | GRC | R_OUT | ZLOW_IN; o = 5'b00011; end
         endcase
         tests++;
         if (ctl !== e || op_sel !== o) begin
            fails++;
            $display("FAIL reset_pre step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=%b", i, ctl, op_sel, e, o);
         end
      end
      #2 clr_n = 1'b0;
      #1;
      tests++;
      if (ctl !== 29'd0 || op_sel !== 5'd0) begin
         fails++;
         $display("FAIL reset_async: ctl=%h op_sel=%b, expected ctl=0 op_sel=0", ctl, op_sel);
      end
      @(posedge clk); #1;
      tests++;
      if (ctl !== 29'd0 || op_sel !== 5'd0) begin
         fails++;
         $display("FAIL reset_hold: ctl=%h op_sel=%b, expected ctl=0 op_sel=0", ctl, op_sel);
      end
      #2 clr_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (ctl !== F0 || op_sel !== 5'd0) begin
         fails++;
         $display("FAIL reset_restart: ctl=%h op_sel=%b, expected ctl=%h op_sel=0", ctl, op_sel, F0);
      end
   endtask

   task automatic test_ldi();
      logic [28:0] ec [7];
      logic [4:0]  eo [7];
      ec = '{F0, F1, F2, A3, A4, WB, F0};
      eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
      start(I_LDI);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         tests++;
         if (ctl !== ec[i] || op_sel !== eo[i]) begin
            fails++;
            $display("FAIL ldi step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=%b", i, ctl, op_sel, ec[i], eo[i]);
         end
      end
   endtask

   task automatic test_add();
      logic [28:0] ec [7];
      logic [4:0]  eo [7];
      ec = '{F0, F1, F2, RUN | GRB | R_OUT | Y_IN, RUN | GRC | R_OUT | ZLOW_IN, WB, F0};
      eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
      start(I_ADD);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         tests++;
         if (ctl !== ec[i] || op_sel !== eo[i]) begin
            fails++;
            $display("FAIL add step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=%b", i, ctl, op_sel, ec[i], eo[i]);
         end
      end
   endtask

   task automatic test_back_to_back_st_ld();
      logic [28:0] ec [17];
      logic [4:0]  eo [17];
      ec = '{F0, F1, F2, A3, A4, RUN | ZLO_OUT | MAR_IN, RUN | GRA | R_OUT | MDR_IN, RUN | WRITE,
             F0, F1, F2, A3, A4, RUN | ZLO_OUT | MAR_IN, RUN | READ | MDR_IN, RUN | MDR_OUT | GRA | R_IN,
             F0};
      eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0,
             5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0};
      start(I_ST);
      for (int i = 0; i < 17; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         tests++;
         if (ctl !== ec[i] || op_sel !== eo[i]) begin
            fails++;
            $display("FAIL st_ld step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=%b", i, ctl, op_sel, ec[i], eo[i]);
         end
         if (i == 7) IR = I_LD;
      end
   endtask

   task automatic test_branch();
      logic [28:0] ec [8];
      logic [4:0]  eo [8];
      for (int cf = 1; cf >= 0; cf--) begin
         ec = '{F0, F1, F2, RUN | GRA | R_OUT | CON_IN, RUN | PC_OUT | Y_IN, A4, RUN, F0};
         eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
         if (cf == 1) ec[6] = RUN | ZLO_OUT | PC_IN;
         CON_FF = (cf == 1);
         start(I_BR);
         for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            tests++;
            if (ctl !== ec[i] || op_sel !== eo[i]) begin
               fails++;
               $display("FAIL br con=%0d step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=%b", cf, i, ctl, op_sel, ec[i], eo[i]);
            end
         end
      end
      CON_FF = 1'b0;
   endtask

`ifdef MULDIV_EN
   localparam int NMISC = 7;
`else
   localparam int NMISC = 8;
`endif

   task automatic test_short_ops();
      logic [28:0] ec [6];
      logic [4:0]  eo [6];
      logic [31:0] ir;
      int          n;
      for (int k = 0; k < NMISC; k++) begin
         ec = '{F0, F1, F2, F0, F0, F0};
         eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
         n  = 4;
         case (k)
            0: begin ir = 32'h80000000; n = 6;            // neg
                      ec[3] = RUN | GRB | R_OUT | ZLOW_IN; eo[3] = 5'b10000; ec[4] = WB; end
            1: begin ir = 32'h60000000; n = 6;            // andi
                      ec[3] = RUN | GRB | R_OUT | Y_IN; ec[4] = A4; eo[4] = 5'b00101; ec[4] = A4; ec[5] = F0;
                      ec[4] = A4; ec[5] = F0; end
            2: begin ir = 32'h98000000; n = 5; ec[3] = RUN | GRA | R_OUT | PC_IN; end   // jr
            3: begin ir = 32'hA8000000; n = 5; ec[3] = RUN | IN_OUT | GRA | R_IN; end  // in
            4: begin ir = 32'hB8000000; n = 5; ec[3] = RUN | HI_OUT | GRA | R_IN; end  // mfhi
            5: ir = I_NOP;
            6: ir = 32'hA0000000;                          // undefined opcode 10100
            default: ir = 32'h70000000;                    // mul without MULDIV_EN
         endcase
         if (k == 1) ec = '{F0, F1, F2, RUN | GRB | R_OUT | Y_IN, A4, WB};
         start(ir);
         for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            tests++;
            if (ctl !== ec[i] || op_sel !== eo[i]) begin
               fails++;
               $display("FAIL short op%0d step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=%b", k, i, ctl, op_sel, ec[i], eo[i]);
            end
         end
         if (k == 1) begin
            @(posedge clk); #1;
            tests++;
            if (ctl !== F0 || op_sel !== 5'd0) begin
               fails++;
               $display("FAIL short andi end: ctl=%h op_sel=%b, expected ctl=%h op_sel=0", ctl, op_sel, F0);
            end
         end
      end
   endtask

   task automatic test_halt();
      start(I_HALT);
      for (int i = 0; i < 15; i++) begin
         logic [28:0] e;
         if (i > 0) begin @(posedge clk); #1; end
         e = (i == 0) ? F0 : (i == 1) ? F1 : (i == 2) ? F2 : 29'd0;
         tests++;
         if (ctl !== e || op_sel !== 5'd0) begin
            fails++;
            $display("FAIL halt step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=0", i, ctl, op_sel, e);
         end
      end
      start(I_NOP);
      tests++;
      if (ctl !== F0 || op_sel !== 5'd0) begin
         fails++;
         $display("FAIL halt_restart: ctl=%h op_sel=%b, expected ctl=%h op_sel=0", ctl, op_sel, F0);
      end
   endtask

   task automatic test_stop();
      logic [28:0] ec [13];
      logic [4:0]  eo [13];
      int          n;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 13; j++) begin ec[j] = 29'd0; eo[j] = 5'd0; end
         ec[0] = F0; ec[1] = F1; ec[2] = F2;
         case (k)
            0: begin n = 13; start(I_NOP); end
            1: begin n = 12; ec[3] = RUN | GRB | R_OUT | Y_IN; ec[4] = RUN | GRC | R_OUT | ZLOW_IN;
                      eo[4] = 5'b00011; ec[5] = WB; start(I_ADD); end
            default: begin n = 5; ec[3] = F0; ec[4] = F1; start(I_NOP); end
         endcase
         for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            tests++;
            if (ctl !== ec[i] || op_sel !== eo[i]) begin
               fails++;
               $display("FAIL stop case%0d step %0d: ctl=%h op_sel=%b, expected ctl=%h op_sel=%b", k, i, ctl, op_sel, ec[i], eo[i]);
            end
            if (k < 2) begin
               if (i == 2) Stop = 1'b1;
               if (i == 3) Stop = 1'b0;
            end else begin
               if (i == 0) Stop = 1'b1;
               if (i == 2) Stop = 1'b0;
            end
         end
         Stop = 1'b0;
      end
   endtask

   initial begin
      clr_n = 1'b0; IR = 32'd0; CON_FF = 1'b0; Stop = 1'b0;
      test_reset();
      test_ldi();
      test_add();
      test_back_to_back_st_ld();
      test_branch();
      test_short_ops();
      test_halt();
      test_stop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
